imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream program loader: writes the instruction memory that the CPU core fetches from.
//  Accepts a framed stream (length, 16-bit instruction words, XOR checksum) over a valid/ready byte port.
//  Writes each word to consecutive instruction-memory addresses starting at 0.
//  Holds the CPU in hold (cpu_hold=1) until a frame loads with a good checksum.
// PARAMETERS
//  DEPTH   256  instruction-memory words; largest legal length field
//  ADDR_W  16   width of mem_addr (matches the 16-bit pc)
// PORTS
//  clk         in   1       single clock; all state updates on posedge clk
//  rst         in   1       synchronous reset, active-high
//  in_valid    in   1       in_byte is valid this cycle
//  in_byte     in   8       stream byte
//  in_ready    out  1       loader accepts in_byte this cycle
//  start       in   1       one-cycle pulse: re-arm the loader from DONE or ERR
//  mem_we      out  1       instruction-memory write strobe, one cycle per word
//  mem_addr    out  ADDR_W  write address
//  mem_wdata   out  16      instruction word {op[15:9], wreg[8:6], rega[5:3], regb[2:0]}
//  cpu_hold    out  1       1 = keep CPU pc/fetch frozen
//  done        out  1       frame loaded, checksum good
//  err         out  1       length overflow or checksum mismatch
//  word_count  out  ADDR_W  words written in the current frame
// BEHAVIOUR
//  Frame format: LEN_H, LEN_L, then N words sent high byte first, then CHK.
//   N = {LEN_H, LEN_L}. CHK = XOR of all 2N data bytes; length bytes are excluded.
//  Handshake: a byte transfers on the posedge where in_valid && in_ready.
//   in_byte must stay stable while in_valid=1 and in_ready=0.
//  in_ready is combinational from state and is 0 while rst=1.
//  Reset: state=LEN_HI, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0.
//   The checksum accumulator and length register are cleared.
//  FSM transitions (states in capitals; in_ready is 1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK):
//   LEN_HI -xfer-> LEN_LO.
//   LEN_LO -xfer-> ERR if N > DEPTH; CHK if N = 0; otherwise DAT_HI.
//   DAT_HI -xfer-> DAT_LO; high byte is latched.
//   DAT_LO -xfer-> WRITE; mem_wdata={hi,lo} and mem_we=1 are registered.
//   WRITE (one cycle, in_ready=0) -> DAT_HI if word_count+1 < N, else CHK.
//   CHK -xfer-> DONE if in_byte == accumulated XOR, else ERR.
//   DONE: done=1, cpu_hold=0. start -> LEN_HI, with done=0, cpu_hold=1, word_count=0, mem_addr=0, acc=0.
//   ERR: err=1, cpu_hold=1. start -> LEN_HI, clearing err and the same registers as DONE.
//  Write timing: low byte accepted at edge t. mem_we=1 with addr/wdata valid during cycle t..t+1 (WRITE state).
//   At edge t+1 memory captures the word, mem_addr increments and word_count increments.
//   mem_we is 1 for exactly one cycle per word. Minimum spacing is 3 cycles per word.
//  mem_addr wraps modulo 2^ADDR_W; this is unreachable because N <= DEPTH.
//  No writes occur after ERR is entered. Words already written are not erased.
//  rst at any time aborts the frame and returns to reset values. Memory contents are left unchanged.
//  start outside DONE/ERR is ignored. in_valid with in_ready=0 is ignored; no byte is lost or consumed.
//  word_count and mem_addr hold their final values in DONE and ERR.
// TESTING
//  1 Stream 00 03 00 01 00 42 00 C3 80 -> three mem_we pulses.
//    Writes are addr0=0001, addr1=0042, addr2=00C3. Then done=1, cpu_hold=0, word_count=3.
//  2 Same frame with CHK=81 -> err=1, cpu_hold=1, done=0. Exactly 3 writes occurred.
//  3 Length 01 01 (257 > DEPTH) -> ERR immediately after LEN_L, no mem_we, in_ready=0 afterwards.
//  4 Stream 00 00 00 -> done=1, word_count=0, no mem_we.
//  5 Frame 1 with in_valid dropped for 1-4 random cycles between bytes.
//    Result identical to case 1; in_ready=0 in every WRITE cycle.
//  6 rst asserted after the 4th byte -> outputs at reset values on the next cycle.
//    Frame 1 then resent -> done. Separately, start from DONE -> second frame loads from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; one registered write per word, >=3 cycles/word.
// Backpressure: in_ready drops in WRITE, DONE and ERR; a held byte is never lost.
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_byte,
  output logic              o_in_ready,
  input  logic              i_start,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_word_count
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [7:0]          r_len_hi;
  logic [15:0]         r_len;
  logic [7:0]          r_dat_hi;
  logic [7:0]          r_acc;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic [ADDR_W-1:0]   r_word_count;

  logic                w_xfer;
  logic [15:0]         w_len;
  logic [ADDR_W:0]     w_wc_inc;
  logic                w_rearm;

  assign o_in_ready = !i_rst && (r_state inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CHK});
  assign w_xfer     = i_in_valid && o_in_ready;
  assign w_len      = {r_len_hi, i_in_byte};
  assign w_wc_inc   = {1'b0, r_word_count} + (ADDR_W+1)'(1);
  assign w_rearm    = i_start && (r_state == S_DONE || r_state == S_ERR);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_LEN_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) begin
        if ({1'b0, w_len} > LP_DEPTH) w_next = S_ERR;
        else if (w_len == 16'd0)      w_next = S_CHK;
        else                          w_next = S_DAT_HI;
      end
      S_DAT_HI: if (w_xfer) w_next = S_DAT_LO;
      S_DAT_LO: if (w_xfer) w_next = S_WRITE;
      S_WRITE:  w_next = (w_wc_inc < (ADDR_W+1)'(r_len)) ? S_DAT_HI : S_CHK;
      S_CHK:    if (w_xfer) w_next = (i_in_byte == r_acc) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (w_rearm) w_next = S_LEN_HI;
      default:  w_next = S_LEN_HI;
    endcase
  end

  // Datapath: length capture, checksum, and the one-cycle write strobe issued from WRITE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi     <= '0;
      r_len        <= '0;
      r_dat_hi     <= '0;
      r_acc        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_word_count <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_LEN_HI: if (w_xfer) r_len_hi <= i_in_byte;
        S_LEN_LO: if (w_xfer) r_len <= w_len;
        S_DAT_HI: if (w_xfer) begin
          r_dat_hi <= i_in_byte;
          r_acc    <= r_acc ^ i_in_byte;
        end
        S_DAT_LO: if (w_xfer) begin
          r_mem_wdata <= {r_dat_hi, i_in_byte};
          r_mem_we    <= 1'b1;
          r_acc       <= r_acc ^ i_in_byte;
        end
        S_WRITE: begin
          r_mem_addr   <= r_mem_addr + ADDR_W'(1);
          r_word_count <= r_word_count + ADDR_W'(1);
        end
        S_DONE,
        S_ERR: if (w_rearm) begin
          r_len_hi     <= '0;
          r_len        <= '0;
          r_acc        <= '0;
          r_mem_addr   <= '0;
          r_word_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_word_count = r_word_count;
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);
  assign o_cpu_hold   = (r_state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized frames against a queue-based model of the expected memory writes and final status.
module tb_imem_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst, in_valid, start;
  logic [7:0]        in_byte;
  logic              in_ready, mem_we, cpu_hold, done, err;
  logic [ADDR_W-1:0] mem_addr, word_count;
  logic [15:0]       mem_wdata;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .i_in_byte(in_byte),
    .o_in_ready(in_ready), .i_start(start), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int rdy_viol = 0;
  logic [31:0] wr_q[$];
  logic [15:0] words[$];

  // Memory-side observer: every strobe is one captured word; the loader must not be accepting bytes then.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      if (in_ready) rdy_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("rdy_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] chk_flip, input int gmin, input int gmax);
    logic [7:0]  x = 8'h00;
    logic [15:0] nn = n[15:0];
    wr_q.delete();
    rdy_viol = 0;
    send_byte(nn[15:8], $urandom_range(gmax, gmin));
    send_byte(nn[7:0],  $urandom_range(gmax, gmin));
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        logic [15:0] w = words[i];
        send_byte(w[15:8], $urandom_range(gmax, gmin));
        send_byte(w[7:0],  $urandom_range(gmax, gmin));
        x = x ^ w[15:8] ^ w[7:0];
      end
      send_byte(x ^ chk_flip, $urandom_range(gmax, gmin));
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int n, input bit good);
    int k  = 0;
    int nw = (n <= DEPTH) ? n : 0;
    while (!(done || err) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("%s.settle", tag),   {31'd0, done | err}, 32'd1);
    check($sformatf("%s.done", tag),     {31'd0, done},       {31'd0, good});
    check($sformatf("%s.err", tag),      {31'd0, err},        {31'd0, !good});
    check($sformatf("%s.cpu_hold", tag), {31'd0, cpu_hold},   {31'd0, !good});
    check($sformatf("%s.word_count", tag), {16'd0, word_count}, 32'(nw));
    check($sformatf("%s.mem_addr", tag),   {16'd0, mem_addr},   32'(nw));
    check($sformatf("%s.in_ready", tag), {31'd0, in_ready}, 32'd0);
    check($sformatf("%s.nwrites", tag),  32'(wr_q.size()), 32'(nw));
    check($sformatf("%s.rdy_in_write", tag), 32'(rdy_viol), 32'd0);
    for (int i = 0; i < nw && i < wr_q.size(); i++)
      check($sformatf("%s.write%0d", tag, i), wr_q[i], {i[15:0], words[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom()));
  endtask

  initial begin
    int n;
    logic [7:0] flip;
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready",   {31'd0, in_ready}, 32'd0);
    check("rst.mem_we",     {31'd0, mem_we},   32'd0);
    check("rst.mem_addr",   {16'd0, mem_addr}, 32'd0);
    check("rst.mem_wdata",  {16'd0, mem_wdata}, 32'd0);
    check("rst.cpu_hold",   {31'd0, cpu_hold}, 32'd1);
    check("rst.done",       {31'd0, done},     32'd0);
    check("rst.err",        {31'd0, err},      32'd0);
    check("rst.word_count", {16'd0, word_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.in_ready", {31'd0, in_ready}, 32'd1);

    words = '{16'h0001, 16'h0042, 16'h00C3};
    send_frame(3, 8'h00, 0, 0);
    check_frame("t1", 3, 1'b1);

    pulse_start();
    check("rearm.done",       {31'd0, done},       32'd0);
    check("rearm.cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("rearm.word_count", {16'd0, word_count}, 32'd0);
    check("rearm.mem_addr",   {16'd0, mem_addr},   32'd0);
    send_frame(3, 8'h01, 0, 0);
    check_frame("t2", 3, 1'b0);

    pulse_start();
    send_frame(257, 8'h00, 0, 0);
    check_frame("t3", 257, 1'b0);

    pulse_start();
    send_frame(0, 8'h00, 0, 0);
    check_frame("t4", 0, 1'b1);

    pulse_start();
    send_frame(3, 8'h00, 1, 4);
    check_frame("t5", 3, 1'b1);

    // Abort mid-frame: the first word is in flight when rst arrives.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6.rst.mem_we",     {31'd0, mem_we},     32'd0);
    check("t6.rst.mem_addr",   {16'd0, mem_addr},   32'd0);
    check("t6.rst.word_count", {16'd0, word_count}, 32'd0);
    check("t6.rst.mem_wdata",  {16'd0, mem_wdata},  32'd0);
    check("t6.rst.cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("t6.rst.in_ready",   {31'd0, in_ready},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_frame(3, 8'h00, 0, 0);
    check_frame("t6", 3, 1'b1);

    pulse_start();
    fill_words(5);
    send_frame(5, 8'h00, 0, 2);
    check_frame("t6b", 5, 1'b1);

    for (int f = 0; f < 6; f++) begin
      pulse_start();
      n = $urandom_range(12, 0);
      fill_words(n);
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      send_frame(n, flip, 0, 3);
      check_frame($sformatf("rand%0d", f), n, flip == 8'h00);
    end

    pulse_start();
    fill_words(DEPTH);
    send_frame(DEPTH, 8'h00, 0, 0);
    check_frame("n256", DEPTH, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
